// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand, MTHI/MTLO and HI/LO result bundle for mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit with MTHI/MTLO writes
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_div_unit_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;     // negate product (mult) or quotient (div)
    logic             neg_r;     // negate remainder: dividend was negative
    logic             div_zero;
    logic [WIDTH-1:0] acc;       // product high half / partial remainder
    logic [WIDTH-1:0] q;         // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] b_op;      // multiplicand / divisor magnitude

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operand magnitudes and sign flags; op[0]=0 selects the signed variants.
    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.src_a[WIDTH-1];
        b_neg     = is_signed & bus.src_b[WIDTH-1];
        abs_a     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
        abs_b     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, b_op} : '0);
        shifted = {acc, q[WIDTH-1]};
        // Partial remainder stays below divisor, so diff[WIDTH] is the borrow.
        diff    = shifted - {1'b0, b_op};
        acc_n   = acc;
        q_n     = q;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                q_n   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted[WIDTH-1:0];
                q_n   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[WIDTH:1];
            q_n   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    // Sign fixup of the magnitude result; divide-by-zero leaves the dividend in acc.
    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~q + 1'b1) : q;
        rem_fix  = neg_r ? (~acc + 1'b1) : acc;
        if (is_div) begin
            res_hi = rem_fix;
            res_lo = div_zero ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            q        <= '0;
            b_op     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) bus.hi <= bus.wr_data;
                    if (bus.lo_we) bus.lo <= bus.wr_data;
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        acc      <= '0;
                        if (bus.op[1]) begin
                            q    <= abs_a;
                            b_op <= abs_b;
                        end else begin
                            q    <= abs_b;
                            b_op <= abs_a;
                        end
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg & bus.op[1];
                        div_zero <= bus.op[1] & (bus.src_b == '0);
                        count    <= CW'(WIDTH - 1);
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    bus.hi   <= res_hi;
                    bus.lo   <= res_lo;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
